// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receive stage.
// The RX pin is double-flopped, a four-state FSM times the start, data
// and stop bits from the detected falling edge, and a completed byte is
// handed to a valid/ready output register that also reports overruns.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_error,
  output logic       overrun
);

  // Clocks per bit and the offset from the start edge to mid-start-bit.
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_WIDTH        = $clog2(SYMBOL_EDGE_TIME);

  // Terminal counts of the bit timer, pre-sized to the timer width.
  localparam logic [CNT_WIDTH-1:0] SYMBOL_LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(SAMPLE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Input synchronizer and edge history
  // ------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;
  logic       rx_prev_reg;

  assign rx_s = sync_reg[1];

  // Two-flop synchronizer; reset to the idle (high) line level so that a
  // reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], serial_in};
    end
  end

  // Previous synchronized level: IDLE only leaves on a genuine 1->0
  // transition, so a line held low (break) cannot retrigger a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev_reg <= 1'b1;
    end else begin
      rx_prev_reg <= rx_s;
    end
  end

  // ------------------------------------------------------------------
  // Receive FSM
  // ------------------------------------------------------------------
  state_t               state_reg,   state_next;
  logic [CNT_WIDTH-1:0] timer_reg,   timer_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [7:0]           shift_reg,   shift_next;

  logic stop_sample;
  logic byte_ok;
  logic byte_bad;

  // State register together with the bit timer, bit index and shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  // Next-state logic: each state counts out its interval on the bit timer
  // and acts on the synchronized line at the terminal count.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;

    case (state_reg)
      IDLE: begin
        if (rx_prev_reg && !rx_s) begin
          state_next = START;
          timer_next = '0;
        end
      end

      START: begin
        if (timer_reg == SAMPLE_LAST) begin
          timer_next = '0;
          if (rx_s) begin
            // Line is back high at mid-start-bit: treat it as a glitch.
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      DATA: begin
        if (timer_reg == SYMBOL_LAST) begin
          timer_next              = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      STOP: begin
        // Return to IDLE at mid-stop-bit so a back-to-back start edge
        // arriving at the end of the stop bit is not missed.
        if (timer_reg == SYMBOL_LAST) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // FSM outputs: the stop-bit sample strobe, split into good and bad.
  always_comb begin
    stop_sample = (state_reg == STOP) && (timer_reg == SYMBOL_LAST);
    byte_ok     = stop_sample && rx_s;
    byte_bad    = stop_sample && !rx_s;
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  logic       byte_done_reg;
  logic       frame_bad_reg;
  logic [7:0] data_out_reg;
  logic       valid_reg;
  logic       frame_error_reg;
  logic       overrun_reg;

  // Capture the stop-bit verdict; the output register acts on it one
  // cycle later while the shifter still holds the finished byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_done_reg <= 1'b0;
      frame_bad_reg <= 1'b0;
    end else begin
      byte_done_reg <= byte_ok;
      frame_bad_reg <= byte_bad;
    end
  end

  // Output register and handshake: a new byte loads when the register is
  // empty or being drained this cycle; otherwise it is dropped and
  // overrun pulses. Error flags are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg    <= '0;
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_error_reg <= frame_bad_reg;
      overrun_reg     <= 1'b0;
      if (byte_done_reg) begin
        if (!valid_reg || data_out_ready) begin
          data_out_reg <= shift_reg;
          valid_reg    <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && data_out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = valid_reg;
  assign frame_error    = frame_error_reg;
  assign overrun        = overrun_reg;

endmodule
